aes_round_sched: RTL and testbench

- Iterative AES-128 encryption round sequencer.
- Holds the 11 expanded round keys and owns the 128-bit state register.
- Performs AddRoundKey internally each round.
- Drives an external combinational round function (SubBytes/ShiftRows/MixColumns) through a same-cycle rf_state/rf_result loop.
- Sits between the block-level valid/ready interface and the round datapath; one block in flight at a time.

---
 rtl/aes_pkg.sv | 16 +
 rtl/aes_key_store.sv | 50 +++++
 rtl/aes_round_sched.sv | 129 ++++++++++++
 tb/tb_aes_round_sched.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types and defaults for the AES-128 round sequencer
package aes_pkg;

  localparam int unsigned N_DEF  = 127;
  localparam int unsigned NR_DEF = 10;
  localparam int unsigned RIDX_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } sched_state_t;

  typedef logic [N_DEF:0] round_key_t;

endpackage

// File: rtl/aes_key_store.sv
// rtl/aes_key_store.sv - round-key register file with range-checked writes
module aes_key_store
  import aes_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned NR = NR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic              i_allow,
  input  logic [RIDX_W-1:0] i_waddr,
  input  logic [N:0]        i_wdata,
  input  logic [RIDX_W-1:0] i_raddr,
  output logic [N:0]        o_rdata,
  output logic              o_err
);

  logic [N:0] r_mem [0:NR];
  logic       r_err;
  logic       w_in_range;
  logic       w_accept;

  assign w_in_range = (i_waddr <= RIDX_W'(NR));
  assign w_accept   = i_we && i_allow && w_in_range;

  // Key storage: cleared on reset, written only when the sequencer allows it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= int'(NR); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_accept) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // One-cycle error pulse for every strobe that could not land.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= i_we && !w_accept;
    end
  end

  assign o_rdata = (i_raddr <= RIDX_W'(NR)) ? r_mem[i_raddr] : '0;
  assign o_err   = r_err;

endmodule

// File: rtl/aes_round_sched.sv
// rtl/aes_round_sched.sv - iterative AES-128 round sequencer with key store
module aes_round_sched
  import aes_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned NR = NR_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_we,
  input  logic [3:0] key_addr,
  input  logic [N:0] key_wdata,
  output logic       key_err,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [N:0] in_block,
  output logic [N:0] rf_state,
  output logic       rf_last,
  input  logic [N:0] rf_result,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [N:0] out_block,
  output logic       busy
);

  sched_state_t      r_fsm;
  sched_state_t      w_fsm_nxt;
  logic [N:0]        r_state;
  logic [RIDX_W-1:0] r_round;
  logic [RIDX_W-1:0] w_rk_addr;
  logic [N:0]        w_rk;
  logic              w_accept;
  logic              w_final;

  // In IDLE the read port serves rk[0] for the initial whitening.
  assign w_rk_addr = (r_fsm == ROUND) ? r_round : '0;
  assign w_final   = (r_round == RIDX_W'(NR));

  aes_key_store #(
    .N  (N),
    .NR (NR)
  ) u_key_store (
    .clk     (clk),
    .rst     (rst),
    .i_we    (key_we),
    .i_allow (r_fsm == IDLE),
    .i_waddr (key_addr),
    .i_wdata (key_wdata),
    .i_raddr (w_rk_addr),
    .o_rdata (w_rk),
    .o_err   (key_err)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm <= IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    w_fsm_nxt = r_fsm;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    rf_last   = 1'b0;
    w_accept  = 1'b0;
    case (r_fsm)
      IDLE: begin
        in_ready = 1'b1;
        w_accept = in_valid;
        if (in_valid) begin
          w_fsm_nxt = ROUND;
        end
      end
      ROUND: begin
        busy    = 1'b1;
        rf_last = w_final;
        if (w_final) begin
          w_fsm_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_fsm_nxt = IDLE;
        end
      end
      default: begin
        w_fsm_nxt = IDLE;
      end
    endcase
  end

  // State register and round counter: whitening on accept, one round per ROUND cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= '0;
      r_round <= '0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (w_accept) begin
            r_state <= in_block ^ w_rk;
            r_round <= RIDX_W'(1);
          end
        end
        ROUND: begin
          r_state <= rf_result ^ w_rk;
          if (!w_final) begin
            r_round <= r_round + RIDX_W'(1);
          end
        end
        default: begin
          r_state <= r_state;
          r_round <= r_round;
        end
      endcase
    end
  end

  assign rf_state  = r_state;
  assign out_block = r_state;

endmodule

// File: tb/tb_aes_round_sched.sv
// tb/tb_aes_round_sched.sv - directed self-checking bench for aes_round_sched
module tb_aes_round_sched;

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PT_INV = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] ONES   = {128{1'b1}};
  localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         key_we = 1'b0;
  logic [3:0]   key_addr = '0;
  logic [127:0] key_wdata = '0;
  logic         key_err;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_block = '0;
  logic [127:0] rf_state;
  logic         rf_last;
  logic [127:0] rf_result;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_block;
  logic         busy;

  logic         use_model = 1'b0;
  logic [127:0] ek [0:10];
  int           n_cmp = 0;
  int           n_bad = 0;

  aes_round_sched dut (
    .clk       (clk),
    .rst       (rst),
    .key_we    (key_we),
    .key_addr  (key_addr),
    .key_wdata (key_wdata),
    .key_err   (key_err),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .rf_state  (rf_state),
    .rf_last   (rf_last),
    .rf_result (rf_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] rf_model(input logic [127:0] s, input logic last);
    logic [7:0]   b [0:15];
    logic [7:0]   t [0:15];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[r+4*c] = b[r+4*((c+r)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o;
  endfunction

  always_comb rf_result = use_model ? rf_model(rf_state, rf_last) : rf_state;

  task automatic build_keys(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox(tmp[31:24]), sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0])};
        tmp = tmp ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) ek[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic write_key(input logic [3:0] a, input logic [127:0] d);
    key_we = 1'b1; key_addr = a; key_wdata = d;
    tick();
    key_we = 1'b0;
  endtask

  task automatic start_block(input logic [127:0] blk);
    in_block = blk; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc, output logic [63:0] mask);
    cyc = 0; mask = '0;
    while (!out_valid && cyc < 50) begin
      if (rf_last) mask[cyc] = 1'b1;
      tick();
      cyc++;
    end
  endtask

  task automatic release_block();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic run_block(input logic [127:0] blk, output logic [127:0] ct,
                           output int cyc, output logic [63:0] mask);
    start_block(blk);
    wait_valid(cyc, mask);
    ct = out_block;
    release_block();
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (key_err !== 1'b0) begin n_bad++; $display("FAIL reset_key_err: got %b want 0", key_err); end
    n_cmp++; if (rf_last !== 1'b0) begin n_bad++; $display("FAIL reset_rf_last: got %b want 0", rf_last); end
    n_cmp++; if (rf_state !== 128'h0) begin n_bad++; $display("FAIL reset_rf_state: got %h want 0", rf_state); end
    n_cmp++; if (out_block !== 128'h0) begin n_bad++; $display("FAIL reset_out_block: got %h want 0", out_block); end
  endtask

  task automatic test_identity();
    logic [127:0] ct; int cyc; logic [63:0] mask;
    use_model = 1'b0;
    do_reset();
    write_key(4'd0, ONES);
    n_cmp++; if (key_err !== 1'b0) begin n_bad++; $display("FAIL ident_key_err: got %b want 0", key_err); end
    run_block(PT, ct, cyc, mask);
    n_cmp++; if (ct !== PT_INV) begin n_bad++; $display("FAIL ident_out: got %h want %h", ct, PT_INV); end
    n_cmp++; if (cyc != 10) begin n_bad++; $display("FAIL ident_latency: got %0d want 10", cyc); end
    n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL ident_idle_after: got ready=%b busy=%b want 1/0", in_ready, busy); end
  endtask

  task automatic test_fips();
    logic [127:0] ct; int cyc; logic [63:0] mask;
    do_reset();
    build_keys(FIPS_K);
    for (int r = 0; r < 11; r++) write_key(4'(r), ek[r]);
    use_model = 1'b1;
    run_block(PT, ct, cyc, mask);
    n_cmp++; if (ct !== FIPS_C) begin n_bad++; $display("FAIL fips_out: got %h want %h", ct, FIPS_C); end
    n_cmp++; if (mask !== 64'h200) begin n_bad++; $display("FAIL fips_rf_last: got %h want 200", mask); end
    n_cmp++; if (cyc != 10) begin n_bad++; $display("FAIL fips_latency: got %0d want 10", cyc); end
  endtask

  task automatic test_backpressure();
    int cyc; logic [63:0] mask;
    start_block(PT);
    wait_valid(cyc, mask);
    in_valid = 1'b1; in_block = ONES;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_hs_%0d: got valid=%b ready=%b want 1/0", i, out_valid, in_ready); end
      n_cmp++; if (out_block !== FIPS_C) begin n_bad++; $display("FAIL bp_out_%0d: got %h want %h", i, out_block, FIPS_C); end
      tick();
    end
    in_valid = 1'b0;
    release_block();
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL bp_release: got valid=%b ready=%b busy=%b want 0/1/0", out_valid, in_ready, busy); end
    use_model = 1'b0;
  endtask

  task automatic test_key_err();
    logic [127:0] ct; int cyc; logic [63:0] mask;
    use_model = 1'b0;
    do_reset();
    write_key(4'd0, ONES);
    start_block(PT);
    write_key(4'd3, 128'ha5a5_5a5a_0f0f_f0f0_1234_5678_9abc_def0);
    n_cmp++; if (key_err !== 1'b1) begin n_bad++; $display("FAIL kerr_round_pulse: got %b want 1", key_err); end
    tick();
    n_cmp++; if (key_err !== 1'b0) begin n_bad++; $display("FAIL kerr_round_clear: got %b want 0", key_err); end
    wait_valid(cyc, mask);
    ct = out_block;
    release_block();
    n_cmp++; if (ct !== PT_INV) begin n_bad++; $display("FAIL kerr_round_out: got %h want %h", ct, PT_INV); end
    write_key(4'd11, 128'h1);
    n_cmp++; if (key_err !== 1'b1) begin n_bad++; $display("FAIL kerr_addr_pulse: got %b want 1", key_err); end
    tick();
    n_cmp++; if (key_err !== 1'b0) begin n_bad++; $display("FAIL kerr_addr_clear: got %b want 0", key_err); end
    run_block(PT, ct, cyc, mask);
    n_cmp++; if (ct !== PT_INV) begin n_bad++; $display("FAIL kerr_after_out: got %h want %h", ct, PT_INV); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] ct; int cyc; logic [63:0] mask;
    use_model = 1'b0;
    write_key(4'd0, ONES);
    write_key(4'd5, 128'h0123_4567_89ab_cdef_0123_4567_89ab_cdef);
    start_block(PT);
    tick(); tick(); tick();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
    do_reset();
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_idle: got valid=%b ready=%b busy=%b want 0/1/0", out_valid, in_ready, busy); end
    n_cmp++; if (rf_state !== 128'h0) begin n_bad++; $display("FAIL rstmid_state: got %h want 0", rf_state); end
    run_block(PT, ct, cyc, mask);
    n_cmp++; if (ct !== PT) begin n_bad++; $display("FAIL rstmid_zero_keys: got %h want %h", ct, PT); end
  endtask

  task automatic test_same_cycle();
    logic [127:0] ct; int cyc; logic [63:0] mask;
    use_model = 1'b0;
    do_reset();
    key_we = 1'b1; key_addr = 4'd0; key_wdata = ONES;
    in_valid = 1'b1; in_block = PT;
    tick();
    key_we = 1'b0; in_valid = 1'b0;
    n_cmp++; if (key_err !== 1'b0) begin n_bad++; $display("FAIL same_key_err: got %b want 0", key_err); end
    wait_valid(cyc, mask);
    ct = out_block;
    release_block();
    n_cmp++; if (ct !== PT) begin n_bad++; $display("FAIL same_old_key: got %h want %h", ct, PT); end
    run_block(PT, ct, cyc, mask);
    n_cmp++; if (ct !== PT_INV) begin n_bad++; $display("FAIL same_new_key: got %h want %h", ct, PT_INV); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_fips();
    test_backpressure();
    test_key_err();
    test_reset_mid();
    test_same_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
